// File: rtl/adder_15b_reg.sv
// Registered signed adder with carry-in, signed-overflow flag and optional saturation.
// Result, flag and valid appear one clock after the operands are presented.
module adder_15b_reg #(
  parameter int WIDTH    = 15,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             overflow,
  output logic             out_valid
);

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Sum is taken one bit wider than the operands so it can never wrap.
  function automatic logic [WIDTH:0] full_sum(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             cin
  );
    return {a[WIDTH-1], a} + {b[WIDTH-1], b} + {{WIDTH{1'b0}}, cin};
  endfunction

  // The wide sum is out of signed range exactly when its top two bits disagree.
  function automatic logic sum_overflows(input logic [WIDTH:0] sum);
    return sum[WIDTH] ^ sum[WIDTH-1];
  endfunction

  // The wide sum's sign bit tells positive from negative overflow.
  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH:0] sum);
    logic [WIDTH-1:0] res;
    case (sum[WIDTH])
      1'b0:    res = MAX_POS;
      1'b1:    res = MIN_NEG;
      default: res = MAX_POS;
    endcase
    return res;
  endfunction

  logic [WIDTH:0]   sum_s;
  logic             ovf_s;
  logic [WIDTH-1:0] res_s;
  logic [WIDTH-1:0] s_r;
  logic             ovf_r;
  logic             valid_r;

  // Next-result datapath: wide sum, overflow detection and optional clamping.
  always_comb begin
    sum_s = full_sum(A, B, Cin);
    ovf_s = sum_overflows(sum_s);
    res_s = sum_s[WIDTH-1:0];
    if (SATURATE && ovf_s) begin
      res_s = clamp(sum_s);
    end else begin
      res_s = sum_s[WIDTH-1:0];
    end
  end

  // Output registers; an invalid cycle only clears valid, so the last result is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_r     <= {WIDTH{1'b0}};
      ovf_r   <= 1'b0;
      valid_r <= 1'b0;
    end else if (in_valid) begin
      s_r     <= res_s;
      ovf_r   <= ovf_s;
      valid_r <= 1'b1;
    end else begin
      valid_r <= 1'b0;
    end
  end

  assign S         = s_r;
  assign overflow  = ovf_r;
  assign out_valid = valid_r;

endmodule

// File: tb/tb_adder_15b_reg.sv
// Directed-table, corner-sequence and random checks of adder_15b_reg,
// wrapping (SATURATE=0) and saturating (SATURATE=1) instances side by side.
module tb_adder_15b_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [14:0] a;
  logic [14:0] b;
  logic        cin;
  logic [14:0] s_w;
  logic [14:0] s_s;
  logic        ovf_w;
  logic        ovf_s;
  logic        vld_w;
  logic        vld_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adder_15b_reg #(.WIDTH(15), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b), .Cin(cin),
    .S(s_w), .overflow(ovf_w), .out_valid(vld_w)
  );

  adder_15b_reg #(.WIDTH(15), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b), .Cin(cin),
    .S(s_s), .overflow(ovf_s), .out_valid(vld_s)
  );

  typedef struct {
    logic [14:0] a;
    logic [14:0] b;
    logic        cin;
    logic [14:0] exp_s;
    logic [14:0] exp_sat;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input int va, input int vb, input logic vc,
                              input int vs, input int vss, input logic vo);
    vec_t v;
    v.a       = 15'(va);
    v.b       = 15'(vb);
    v.cin     = vc;
    v.exp_s   = 15'(vs);
    v.exp_sat = 15'(vss);
    v.exp_ovf = vo;
    return v;
  endfunction

  task automatic chk15(input string name, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name,
               $signed(act), act, $signed(exp), exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [14:0] va, input logic [14:0] vb, input logic vc);
    in_valid = v;
    a        = va;
    b        = vb;
    cin      = vc;
  endtask

  // Advance one edge and move off it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          full;
  logic [14:0] m_s;
  logic [14:0] m_sat;
  logic        m_ovf;
  logic        m_vld;

  initial begin
    vecs[0]  = mk(10, 20, 1'b0, 30, 30, 1'b0);
    vecs[1]  = mk(-10, 50, 1'b0, 40, 40, 1'b0);
    vecs[2]  = mk(-100, 77, 1'b0, -23, -23, 1'b0);
    vecs[3]  = mk(-517, -473, 1'b0, -990, -990, 1'b0);
    vecs[4]  = mk(-9485, -15427, 1'b0, 7856, -16384, 1'b1);
    vecs[5]  = mk(15091, 5053, 1'b0, -12624, 16383, 1'b1);
    vecs[6]  = mk(0, 15091, 1'b0, 15091, 15091, 1'b0);
    vecs[7]  = mk(16383, 0, 1'b1, -16384, 16383, 1'b1);
    vecs[8]  = mk(-1, 0, 1'b1, 0, 0, 1'b0);
    vecs[9]  = mk(-16384, -1, 1'b0, 16383, -16384, 1'b1);
    vecs[10] = mk(-16384, 0, 1'b1, -16383, -16383, 1'b0);
    vecs[11] = mk(5000, -5000, 1'b1, 1, 1, 1'b0);

    // Reset held for two edges while in_valid is high.
    rst = 1'b1;
    drive(1'b1, 15'd10, 15'd20, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk15("reset_s", s_w, 15'd0);
      chk1("reset_ovf", ovf_w, 1'b0);
      chk1("reset_valid", vld_w, 1'b0);
      chk1("reset_valid_sat", vld_s, 1'b0);
    end
    rst = 1'b0;

    // Table vectors back-to-back: each result appears exactly one edge later.
    drive(1'b1, vecs[0].a, vecs[0].b, vecs[0].cin);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk15($sformatf("vec%0d_s", i), s_w, vecs[i].exp_s);
      chk1($sformatf("vec%0d_ovf", i), ovf_w, vecs[i].exp_ovf);
      chk1($sformatf("vec%0d_valid", i), vld_w, 1'b1);
      chk15($sformatf("vec%0d_sat_s", i), s_s, vecs[i].exp_sat);
      chk1($sformatf("vec%0d_sat_ovf", i), ovf_s, vecs[i].exp_ovf);
      if (i < 11) begin
        drive(1'b1, vecs[i+1].a, vecs[i+1].b, vecs[i+1].cin);
      end else begin
        drive(1'b1, 15'd100, 15'd200, 1'b0);
      end
    end

    // One-cycle valid drop holds S and clears out_valid.
    tick();
    chk15("pre_drop_s", s_w, 15'd300);
    drive(1'b0, 15'd1234, 15'd4321, 1'b1);
    tick();
    chk1("drop_valid", vld_w, 1'b0);
    chk15("drop_s_held", s_w, 15'd300);
    drive(1'b1, 15'd1, 15'd2, 1'b0);
    tick();
    chk1("resume_valid", vld_w, 1'b1);
    chk15("resume_s", s_w, 15'd3);

    // Reset mid-stream discards the in-flight add.
    rst = 1'b1;
    drive(1'b1, 15'd7, 15'd8, 1'b0);
    tick();
    chk15("midrst_s", s_w, 15'd0);
    chk1("midrst_valid", vld_w, 1'b0);
    rst = 1'b0;
    drive(1'b1, 15'd4, 15'd5, 1'b0);
    tick();
    chk1("post_rst_valid", vld_w, 1'b1);
    chk15("post_rst_s", s_w, 15'd9);

    // Random signed stimulus against an integer-range model.
    m_s   = s_w;
    m_sat = s_s;
    m_ovf = ovf_w;
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            15'($urandom), 15'($urandom), 1'($urandom));
      if (in_valid) begin
        full  = int'($signed(a)) + int'($signed(b)) + int'(cin);
        m_ovf = (full > 16383) || (full < -16384);
        m_s   = 15'(full);
        if (full > 16383) begin
          m_sat = 15'(16383);
        end else if (full < -16384) begin
          m_sat = 15'(-16384);
        end else begin
          m_sat = 15'(full);
        end
      end
      m_vld = in_valid;
      tick();
      chk15("rand_s", s_w, m_s);
      chk1("rand_ovf", ovf_w, m_ovf);
      chk1("rand_valid", vld_w, m_vld);
      chk15("rand_sat_s", s_s, m_sat);
      chk1("rand_sat_ovf", ovf_s, m_ovf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
